// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the memory-access stage
package mem_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - data memory array with async read and sync write
//
// Ports:
//   clk    write clock
//   we     write enable; the stage raises it only on the edge a store completes
//   addr   word address, shared by the read and write ports
//   wdata  store data
//   rdata  combinational read of mem[addr]
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    // Contents are intentionally never reset.
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: fixed-latency data access, stall, MEM/WB register
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   ALUres          byte address for loads/stores, pass-through value otherwise
//   Data            store data
//   DestReg         destination register number
//   MemRd, MemWr    load / store request (both high is a store)
//   WrReg           register-file write enable
//   DataSrc         write-back select (1 = memory data, 0 = ALU result)
//   Stall           holds the upstream stages while an access is still in flight
//   ReadDataOut, ALUresOut, DestRegOut, WrRegOut, DataSrcOut   MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] ALUres,
    input  logic [WORD_W-1:0] Data,
    input  logic [REG_W-1:0]  DestReg,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic              WrReg,
    input  logic              DataSrc,
    output logic              Stall,
    output logic [WORD_W-1:0] ReadDataOut,
    output logic [WORD_W-1:0] ALUresOut,
    output logic [REG_W-1:0]  DestRegOut,
    output logic              WrRegOut,
    output logic              DataSrcOut
);

    localparam int AW = $clog2(DEPTH);
    // The IDLE cycle and the final cnt==0 cycle both count toward LAT.
    localparam int               LAT_M2   = (LAT > 1) ? LAT - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_M2);
    localparam logic             SINGLE   = (LAT == 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op;
    logic              done;
    logic              load;
    logic              we;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] rdata;

    // Byte-offset bits are dropped; upper bits fall off so addresses wrap.
    assign addr = ALUres[AW+1:2];
    assign op   = MemRd | MemWr;
    assign load = MemRd & ~MemWr;
    assign done = ((state == IDLE) && SINGLE) || ((state == BUSY) && (cnt == '0));
    assign Stall = op & ~done;
    // rst gating keeps a store presented during reset from committing.
    assign we   = MemWr & done & rst;

    data_mem #(.DEPTH(DEPTH)) u_data_mem (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (Data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ReadDataOut <= '0;
            ALUresOut   <= '0;
            DestRegOut  <= '0;
            WrRegOut    <= 1'b0;
            DataSrcOut  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op && !SINGLE) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (Stall) begin
                // Bubble: downstream sees no register write, other fields hold.
                WrRegOut <= 1'b0;
            end else begin
                ReadDataOut <= load ? rdata : '0;
                ALUresOut   <= ALUres;
                DestRegOut  <= DestReg;
                WrRegOut    <= WrReg;
                DataSrcOut  <= DataSrc;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs: address, store data, destination register and control bits. It performs the data-memory access with a fixed multi-cycle latency, stalls the upstream stages while an access is in flight, and registers the results into the MEM/WB boundary.

## Interface
Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of two.
- LAT, 1: cycles per memory access, 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ALUres  in  32  byte address for memory ops; pass-through value otherwise.
- Data  in  32  store data.
- DestReg  in  5  destination register number.
- MemRd  in  1  load request.
- MemWr  in  1  store request.
- WrReg  in  1  register-file write enable.
- DataSrc  in  1  write-back mux select: 1 selects memory data, 0 selects the ALU result.
- Stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers while high.
- ReadDataOut  out  32  registered load data.
- ALUresOut  out  32  registered ALU result.
- DestRegOut  out  5  registered destination register.
- WrRegOut  out  1  registered write enable.
- DataSrcOut  out  1  registered write-back select.

## Operation
- Word address = ALUres[log2(DEPTH)+1:2].
  - Bits [1:0] are ignored.
  - Upper bits are discarded, so addresses wrap modulo DEPTH.
- A memory op is MemRd | MemWr.
  - If both are high, the op is a store; ReadDataOut is 0.
- FSM has two states.
  - IDLE: no access in flight.
  - BUSY: access in flight; 4-bit down-counter cnt.
- done = (IDLE and LAT==1) or (BUSY and cnt==0).
- Stall = op and not done. Stall is combinational from the inputs and state.
- Transitions:
  - IDLE, op, LAT>1 → BUSY with cnt = LAT-2.
  - BUSY, cnt!=0 → cnt decrements.
  - BUSY, cnt==0 → IDLE.
- Upstream holds every input stable while Stall is high.
- Edge with done or no op: the MEM/WB register loads normally.
  - ALUresOut, DestRegOut and DataSrcOut take their inputs.
  - WrRegOut = WrReg.
  - ReadDataOut = mem[addr] for a load, otherwise 0.
  - A store commits to memory at this edge.
- Edge with Stall high: a bubble is inserted.
  - WrRegOut = 0; other MEM/WB outputs are unchanged.
  - Memory is not written.
- Memory read is combinational from the word address. A store followed by a load to the same address returns the new data.

## Timing
- Reset (rst low), asynchronous:
  - State = IDLE, cnt = 0.
  - ReadDataOut, ALUresOut, DestRegOut, WrRegOut, DataSrcOut = 0.
  - Stall follows its equation with state = IDLE.
- Memory array contents are not reset.
- Reset during BUSY aborts the access; a pending store is never written.
- Non-memory instruction: one-cycle latency, Stall never asserted.
- Memory op: LAT cycles total.
  - Stall is high for LAT-1 cycles, starting the cycle the op appears.
  - The result is visible in MEM/WB one edge after the last (non-stalled) cycle.
- Back-to-back memory ops: the second op sees IDLE on the cycle after the first completes and starts a fresh LAT-cycle access. There is no overlap.

## Structure
- Shared package mem_stage_pkg:
  - state enum {IDLE, BUSY}.
  - Constants WORD_W=32, REG_W=5, CNT_W=4.
- Sub-module data_mem, holding the memory array:
  - DEPTH words.
  - Asynchronous read port.
  - Synchronous write port, gated by a write-enable that mem_stage drives with MemWr & done.
- mem_stage contains the FSM, the Stall logic and the MEM/WB register.

## Test plan
- Reset with ALUres=0x10 and WrReg=1 held at inputs → all outputs 0 during and after reset. With no op present, first edge after release gives ALUresOut=0x10, WrRegOut=1.
- LAT=1: store Data=0xDEADBEEF at ALUres=0x20, next cycle load 0x20 with DataSrc=1 → Stall never high; ReadDataOut=0xDEADBEEF one edge after the load.
- LAT=3: load at 0x40 holding 0x12345678 → Stall high 2 cycles; WrRegOut=0 on those edges; third edge gives ReadDataOut=0x12345678, WrRegOut=1.
- LAT=3: store 0x5 at 0x44, then load 0x44 → stores and loads stall 2 cycles each; load returns 0x5. Memory unchanged until the store's third cycle.
- LAT=4: rst pulsed low in the second BUSY cycle of a store of 0xAA to 0x8 → outputs 0, state IDLE, mem[2] keeps its prior value.
- DEPTH=256: store 0x77 to ALUres=0x403, then load 0x000 → returns 0x77 (wrap plus ignored byte bits). MemRd=MemWr=1 → treated as store, ReadDataOut=0.
